// File: rtl/awgn_pkg.sv
// Shared types and widths for the AWGN uniform-pair front end.
package awgn_pkg;

  localparam int unsigned URNG_W = 32;
  localparam int unsigned U0_W   = 48;
  localparam int unsigned U1_W   = 16;

  typedef struct packed {
    logic [U0_W-1:0] u0;
    logic [U1_W-1:0] u1;
  } pair_t;

  typedef enum logic {
    PH_EVEN = 1'b0,
    PH_ODD  = 1'b1
  } phase_e;

  // u0 takes the whole even word plus the top half of the odd word.
  function automatic pair_t make_pair(input logic [URNG_W-1:0] hold,
                                      input logic [URNG_W-1:0] word);
    pair_t p;
    p.u0 = {hold, word[31:16]};
    p.u1 = word[15:0];
    return p;
  endfunction

endpackage

// File: rtl/pair_fifo.sv
// Synchronous FIFO of u0/u1 pairs; storage is not reset, only pointers and count.
module pair_fifo
  import awgn_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  pair_t                  data_i,
  input  logic                   pop_i,
  output pair_t                  data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned AW = $clog2(Depth);

  pair_t          mem_q [Depth];
  logic [AW-1:0]  wptr_q, wptr_d;
  logic [AW-1:0]  rptr_q, rptr_d;
  logic [AW:0]    count_q, count_d;
  logic           do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(Depth));
  assign count_o = count_q;
  assign data_o  = mem_q[rptr_q];

  // A push into a full FIFO only lands when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/urng_pair_packer.sv
// Discards URNG warm-up words, pairs consecutive words into u0/u1 and buffers the pairs.
module urng_pair_packer
  import awgn_pkg::*;
#(
  parameter int unsigned WARMUP = 3,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DROPW  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      in_word,
  input  logic             in_valid,
  output logic [47:0]      u0,
  output logic [15:0]      u1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DROPW-1:0] drop_cnt,
  output logic             warm
);

  logic [7:0]       warm_cnt_q;
  logic             warm_q;
  phase_e           phase_q;
  logic [31:0]      hold_q;
  logic [DROPW-1:0] drop_cnt_q;

  logic                   pair_req, pop, drop;
  logic                   fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  pair_t                  head;
  logic                   unused_count;

  assign pair_req = warm_q & (phase_q == PH_ODD) & in_valid;
  assign pop      = ~fifo_empty & out_ready;
  assign drop     = pair_req & fifo_full & ~pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      warm_cnt_q <= '0;
      warm_q     <= 1'b0;
      phase_q    <= PH_EVEN;
      hold_q     <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (!warm_q) begin
        if (WARMUP == 0) begin
          warm_q <= 1'b1;
        end else if (in_valid) begin
          if (warm_cnt_q == 8'(WARMUP - 1)) warm_q <= 1'b1;
          warm_cnt_q <= warm_cnt_q + 8'd1;
        end
      end else if (in_valid) begin
        // A gap simply holds the phase, so the held word waits for its partner.
        case (phase_q)
          PH_EVEN: begin
            hold_q  <= in_word;
            phase_q <= PH_ODD;
          end
          PH_ODD:  phase_q <= PH_EVEN;
          default: phase_q <= PH_EVEN;
        endcase
      end
      if (drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  pair_fifo #(
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (pair_req),
    .data_i  (make_pair(hold_q, in_word)),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign unused_count = ^fifo_count;

  // Storage is not reset, so the head is forced to zero while nothing is buffered.
  assign u0        = fifo_empty ? '0 : head.u0;
  assign u1        = fifo_empty ? '0 : head.u1;
  assign out_valid = ~fifo_empty;
  assign drop_cnt  = drop_cnt_q;
  assign warm      = warm_q;

endmodule

// File: tb/tb_urng_pair_packer.sv
// Directed bench for urng_pair_packer: vector table plus full/drop and reset sequences.
module tb_urng_pair_packer;

  logic        clk;
  logic        reset;
  logic [31:0] in_word;
  logic        in_valid;
  logic [47:0] u0;
  logic [15:0] u1;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] drop_cnt;
  logic        warm;

  int checks = 0;
  int errors = 0;

  urng_pair_packer #(
    .WARMUP (3),
    .DEPTH  (4),
    .DROPW  (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_word   (in_word),
    .in_valid  (in_valid),
    .u0        (u0),
    .u1        (u1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .drop_cnt  (drop_cnt),
    .warm      (warm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    logic        v;
    logic        r;
    logic        ev;
    logic        ewarm;
    logic [47:0] eu0;
    logic [15:0] eu1;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(logic [31:0] w, logic v, logic r, logic ev, logic ewarm,
                              logic [47:0] eu0, logic [15:0] eu1);
    vec_t t;
    t.w = w; t.v = v; t.r = r; t.ev = ev; t.ewarm = ewarm; t.eu0 = eu0; t.eu1 = eu1;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] w, input logic v, input logic r);
    in_word   = w;
    in_valid  = v;
    out_ready = r;
  endtask

  task automatic chk_head(input string name, input logic ev, input logic [47:0] eu0,
                          input logic [15:0] eu1);
    chk({name, ".valid"}, 64'(out_valid), 64'(ev));
    chk({name, ".u0"}, 64'(u0), 64'(eu0));
    chk({name, ".u1"}, 64'(u1), 64'(eu1));
  endtask

  initial begin
    reset = 1'b0;
    drive(32'h0, 1'b0, 1'b0);

    tbl[0]  = mk(32'h00000001, 1, 0, 0, 0, 48'h0, 16'h0);
    tbl[1]  = mk(32'h00000002, 1, 0, 0, 0, 48'h0, 16'h0);
    tbl[2]  = mk(32'h00000003, 1, 0, 0, 1, 48'h0, 16'h0);
    tbl[3]  = mk(32'h00000004, 1, 0, 0, 1, 48'h0, 16'h0);
    tbl[4]  = mk(32'h00000005, 1, 0, 1, 1, 48'h000000040000, 16'h0005);
    tbl[5]  = mk(32'h00000006, 1, 0, 1, 1, 48'h000000040000, 16'h0005);
    tbl[6]  = mk(32'h00000000, 0, 1, 0, 1, 48'h0, 16'h0);
    tbl[7]  = mk(32'h00000007, 1, 0, 1, 1, 48'h000000060000, 16'h0007);
    tbl[8]  = mk(32'h00000000, 0, 1, 0, 1, 48'h0, 16'h0);
    tbl[9]  = mk(32'hDEADBEEF, 1, 0, 0, 1, 48'h0, 16'h0);
    tbl[10] = mk(32'h12345678, 1, 0, 1, 1, 48'hDEADBEEF1234, 16'h5678);
    tbl[11] = mk(32'h00000000, 0, 1, 0, 1, 48'h0, 16'h0);
    tbl[12] = mk(32'hAAAAAAAA, 1, 0, 0, 1, 48'h0, 16'h0);
    tbl[13] = mk(32'h13579BDF, 0, 0, 0, 1, 48'h0, 16'h0);
    tbl[14] = mk(32'h13579BDF, 0, 0, 0, 1, 48'h0, 16'h0);
    tbl[15] = mk(32'h13579BDF, 0, 0, 0, 1, 48'h0, 16'h0);
    tbl[16] = mk(32'h13579BDF, 0, 0, 0, 1, 48'h0, 16'h0);
    tbl[17] = mk(32'h13579BDF, 0, 0, 0, 1, 48'h0, 16'h0);
    tbl[18] = mk(32'h5555FFFF, 1, 0, 1, 1, 48'hAAAAAAAA5555, 16'hFFFF);
    tbl[19] = mk(32'h00000000, 0, 1, 0, 1, 48'h0, 16'h0);

    // Reset state while held in reset across a couple of edges.
    step();
    step();
    chk_head("reset", 1'b0, 48'h0, 16'h0);
    chk("reset.warm", 64'(warm), 64'd0);
    chk("reset.drop", 64'(drop_cnt), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].w, tbl[i].v, tbl[i].r);
      step();
      chk_head($sformatf("vec%0d", i), tbl[i].ev, tbl[i].eu0, tbl[i].eu1);
      chk($sformatf("vec%0d.warm", i), 64'(warm), 64'(tbl[i].ewarm));
      chk($sformatf("vec%0d.drop", i), 64'(drop_cnt), 64'd0);
    end

    // Full/drop: 12 words with the consumer stalled, then drain.
    for (int i = 0; i < 12; i++) begin
      drive(32'h100 + 32'(i), 1'b1, 1'b0);
      step();
    end
    drive(32'h0, 1'b0, 1'b0);
    chk("full.drop", 64'(drop_cnt), 64'd2);
    chk("full.valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk_head($sformatf("drain%0d", k), 1'b1, {32'h100 + 32'(2 * k), 16'h0000},
               16'h101 + 16'(2 * k));
      step();
    end
    chk_head("drain.empty", 1'b0, 48'h0, 16'h0);

    // Full with a pop on the cycle the fifth pair completes.
    for (int i = 0; i < 8; i++) begin
      drive(32'h200 + 32'(i), 1'b1, 1'b0);
      step();
    end
    drive(32'h208, 1'b1, 1'b0);
    step();
    chk("fullpop.pre_drop", 64'(drop_cnt), 64'd2);
    drive(32'h209, 1'b1, 1'b1);
    step();
    chk("fullpop.drop", 64'(drop_cnt), 64'd2);
    drive(32'h0, 1'b0, 1'b1);
    for (int k = 1; k < 4; k++) begin
      chk_head($sformatf("fullpop%0d", k), 1'b1, {32'h200 + 32'(2 * k), 16'h0000},
               16'h201 + 16'(2 * k));
      step();
    end
    chk_head("fullpop.new", 1'b1, 48'h000002080000, 16'h0209);
    step();
    chk_head("fullpop.empty", 1'b0, 48'h0, 16'h0);

    // Asynchronous reset between the even and odd word with a pair buffered.
    drive(32'h300, 1'b1, 1'b0);
    step();
    drive(32'h301, 1'b1, 1'b0);
    step();
    drive(32'h302, 1'b1, 1'b0);
    step();
    chk("prereset.valid", 64'(out_valid), 64'd1);
    drive(32'h0, 1'b0, 1'b0);
    #3;
    reset = 1'b0;
    #1;
    chk_head("async", 1'b0, 48'h0, 16'h0);
    chk("async.warm", 64'(warm), 64'd0);
    chk("async.drop", 64'(drop_cnt), 64'd0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    drive(32'h11, 1'b1, 1'b0);
    step();
    chk("rewarm0", 64'(warm), 64'd0);
    drive(32'h22, 1'b1, 1'b0);
    step();
    chk("rewarm1", 64'(warm), 64'd0);
    drive(32'h33, 1'b1, 1'b0);
    step();
    chk("rewarm2", 64'(warm), 64'd1);
    drive(32'h44, 1'b1, 1'b0);
    step();
    chk_head("rehold", 1'b0, 48'h0, 16'h0);
    drive(32'h55, 1'b1, 1'b0);
    step();
    chk_head("repair", 1'b1, 48'h000000440000, 16'h0055);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
